// File: rtl/axi_helper_pkg.sv
// Shared AXI4 types and burst address arithmetic for the burst subordinate memory.
package axi_helper_pkg;

  typedef enum logic [1:0] {
    BurstFixed = 2'b00,
    BurstIncr  = 2'b01,
    BurstWrap  = 2'b10,
    BurstRsvd  = 2'b11
  } burst_t;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespSlverr = 2'b10
  } resp_t;

  function automatic logic axi_wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  function automatic logic axi_bad_burst(input logic [7:0] len, input burst_t burst);
    return (burst == BurstRsvd) || ((burst == BurstWrap) && !axi_wrap_len_ok(len));
  endfunction

  // Bad bursts fall through to INCR stepping; WRAP windows are power-of-two sized.
  function automatic logic [63:0] axi_next_addr(input logic [63:0] addr, input logic [7:0] len,
                                                input burst_t burst, input int unsigned bytes);
    logic [63:0] step;
    logic [63:0] wsize;
    logic [63:0] next;
    step  = 64'(bytes);
    wsize = (64'(len) + 64'd1) * step;
    next  = addr + step;
    if (burst == BurstFixed) begin
      next = addr;
    end else if ((burst == BurstWrap) && axi_wrap_len_ok(len)) begin
      next = (addr & ~(wsize - 64'd1)) | (next & (wsize - 64'd1));
    end
    return next;
  endfunction

endpackage

// File: rtl/axi_burst_mem_sub_addr_gen.sv
// Per-path burst address generator: tracks base, length, burst type and beat count.
module axi_burst_addr_gen
  import axi_helper_pkg::*;
#(
  parameter int unsigned AddrW     = 32,
  parameter int unsigned BeatBytes = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [7:0]       len_i,
  input  logic [1:0]       burst_i,
  input  logic             adv_i,
  output logic [AddrW-1:0] addr_o,
  output logic [AddrW-1:0] next_addr_o,
  output logic             last_o,
  output logic             next_last_o,
  output logic             bad_o
);

  logic [AddrW-1:0] addr_q;
  logic [7:0]       len_q;
  logic [1:0]       burst_q;
  logic [7:0]       cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      len_q   <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
    end else if (load_i) begin
      addr_q  <= addr_i;
      len_q   <= len_i;
      burst_q <= burst_i;
      cnt_q   <= '0;
    end else if (adv_i) begin
      addr_q  <= next_addr_o;
      cnt_q   <= cnt_q + 8'd1;
    end
  end

  assign addr_o      = addr_q;
  assign next_addr_o = AddrW'(axi_next_addr(64'(addr_q), len_q, burst_t'(burst_q), BeatBytes));
  assign last_o      = (cnt_q == len_q);
  assign next_last_o = ((cnt_q + 8'd1) == len_q);
  assign bad_o       = axi_bad_burst(len_q, burst_t'(burst_q));

endmodule

// File: rtl/axi_burst_mem_sub.sv
// AXI4 burst subordinate memory: independent write (AW/W/B) and read (AR/R) FSMs over one array.
module axi_burst_mem_sub
  import axi_helper_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [ID_W-1:0]     AWID,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [7:0]          AWLEN,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [ID_W-1:0]     BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ID_W-1:0]     ARID,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [7:0]          ARLEN,
  input  logic [1:0]          ARBURST,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [ID_W-1:0]     RID,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY
);

  localparam int unsigned Bytes = DATA_W / 8;
  localparam int unsigned Off   = $clog2(Bytes);
  localparam int unsigned MemAw = $clog2(MEM_BYTES);
  localparam int unsigned Words = MEM_BYTES / Bytes;
  localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(Bytes - 1);

  typedef enum logic [1:0] {WIdle, WData, WResp} wstate_e;
  typedef enum logic {RIdle, RData} rstate_e;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 64'(a) < 64'(MEM_BYTES);
  endfunction

  logic [DATA_W-1:0] mem_q [Words];

  // Write path state
  wstate_e         wstate_q;
  logic            awready_q, wready_q, bvalid_q, werr_q;
  logic [ID_W-1:0] wid_q, bid_q;
  logic [1:0]      bresp_q;
  logic [ADDR_W-1:0] w_addr, w_next_addr;
  logic            w_last, w_next_last, w_bad, w_oor, werr_d, aw_hs, w_hs;

  assign aw_hs  = AWVALID && awready_q;
  assign w_hs   = WVALID && wready_q;
  assign w_oor  = !in_range(w_addr);
  assign werr_d = werr_q || w_bad || w_oor || (WLAST != w_last);

  axi_burst_addr_gen #(.AddrW(ADDR_W), .BeatBytes(Bytes)) u_wgen (
    .clk_i      (ACLK),
    .rst_ni     (ARESETn),
    .load_i     (aw_hs),
    .addr_i     (AWADDR & AlignMask),
    .len_i      (AWLEN),
    .burst_i    (AWBURST),
    .adv_i      (w_hs),
    .addr_o     (w_addr),
    .next_addr_o(w_next_addr),
    .last_o     (w_last),
    .next_last_o(w_next_last),
    .bad_o      (w_bad)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wstate_q  <= WIdle;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      werr_q    <= 1'b0;
      wid_q     <= '0;
      bid_q     <= '0;
      bresp_q   <= RespOkay;
    end else begin
      unique case (wstate_q)
        WIdle: if (aw_hs) begin
          wid_q     <= AWID;
          werr_q    <= 1'b0;
          awready_q <= 1'b0;
          wready_q  <= 1'b1;
          wstate_q  <= WData;
        end
        WData: if (w_hs) begin
          werr_q <= werr_d;
          // The LEN-th beat closes the burst whatever WLAST says.
          if (w_last) begin
            wready_q <= 1'b0;
            bvalid_q <= 1'b1;
            bid_q    <= wid_q;
            bresp_q  <= werr_d ? RespSlverr : RespOkay;
            wstate_q <= WResp;
          end
        end
        WResp: if (BREADY) begin
          bvalid_q  <= 1'b0;
          awready_q <= 1'b1;
          wstate_q  <= WIdle;
        end
        default: wstate_q <= WIdle;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_hs && !w_oor) begin
      for (int k = 0; k < int'(Bytes); k++) begin
        if (WSTRB[k]) mem_q[w_addr[MemAw-1:Off]][8*k +: 8] <= WDATA[8*k +: 8];
      end
    end
  end

  // Read path state
  rstate_e           rstate_q;
  logic              arready_q, rvalid_q, rlast_q;
  logic [ID_W-1:0]   rid_q;
  logic [DATA_W-1:0] rdata_q, r_ld_data;
  logic [1:0]        rresp_q;
  logic [ADDR_W-1:0] r_addr, r_next_addr, r_ld_addr;
  logic              r_last, r_next_last, r_bad, r_ld_bad, r_ld_last, ar_hs, r_hs;

  assign ar_hs = ARVALID && arready_q;
  assign r_hs  = rvalid_q && RREADY;

  axi_burst_addr_gen #(.AddrW(ADDR_W), .BeatBytes(Bytes)) u_rgen (
    .clk_i      (ACLK),
    .rst_ni     (ARESETn),
    .load_i     (ar_hs),
    .addr_i     (ARADDR & AlignMask),
    .len_i      (ARLEN),
    .burst_i    (ARBURST),
    .adv_i      (r_hs && !rlast_q),
    .addr_o     (r_addr),
    .next_addr_o(r_next_addr),
    .last_o     (r_last),
    .next_last_o(r_next_last),
    .bad_o      (r_bad)
  );

  // Beat 0 comes straight from AR; later beats from the generator's next address.
  always_comb begin
    r_ld_addr = r_next_addr;
    r_ld_bad  = r_bad;
    r_ld_last = r_next_last;
    if (rstate_q == RIdle) begin
      r_ld_addr = ARADDR & AlignMask;
      r_ld_bad  = axi_bad_burst(ARLEN, burst_t'(ARBURST));
      r_ld_last = (ARLEN == 8'd0);
    end
    r_ld_data = '0;
    if (in_range(r_ld_addr)) r_ld_data = mem_q[r_ld_addr[MemAw-1:Off]];
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rstate_q  <= RIdle;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= RespOkay;
    end else begin
      unique case (rstate_q)
        RIdle: if (ar_hs) begin
          rid_q     <= ARID;
          rdata_q   <= r_ld_data;
          rresp_q   <= (r_ld_bad || !in_range(r_ld_addr)) ? RespSlverr : RespOkay;
          rlast_q   <= r_ld_last;
          rvalid_q  <= 1'b1;
          arready_q <= 1'b0;
          rstate_q  <= RData;
        end
        RData: if (r_hs) begin
          if (rlast_q) begin
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            arready_q <= 1'b1;
            rstate_q  <= RIdle;
          end else begin
            rdata_q <= r_ld_data;
            rresp_q <= (r_ld_bad || !in_range(r_ld_addr)) ? RespSlverr : RespOkay;
            rlast_q <= r_ld_last;
          end
        end
        default: rstate_q <= RIdle;
      endcase
    end
  end

  logic unused_gen;
  assign unused_gen = ^{w_next_addr, w_next_last, r_addr, r_last};

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BID     = bid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RID     = rid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;
  assign RLAST   = rlast_q;

endmodule

// File: tb/tb_axi_burst_mem_sub.sv
// Self-checking bench for axi_burst_mem_sub against a byte-array reference model.
module tb_axi_burst_mem_sub;

  localparam int MB = 4096;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [3:0]  AWID, ARID, BID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [7:0]  AWLEN, ARLEN;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

  axi_burst_mem_sub #(.DATA_W(32), .ADDR_W(32), .ID_W(4), .MEM_BYTES(MB)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  logic [7:0]  ref_mem [MB];
  logic [31:0] wdat [256];
  logic [3:0]  wstb [256];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Closed-form address of beat i of a burst.
  function automatic longint unsigned beat_addr(input longint unsigned base, input int len,
                                                input int burst, input int i);
    longint unsigned a0, ws, lo;
    a0 = base & ~64'd3;
    if (burst == 0) return a0;
    if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      ws = longint'(len + 1) * 4;
      lo = (a0 / ws) * ws;
      return lo + ((a0 - lo + longint'(i) * 4) % ws);
    end
    return a0 + longint'(i) * 4;
  endfunction

  function automatic bit bad_burst(input int len, input int burst);
    return burst == 3 || (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  function automatic logic [31:0] ref_word(input longint unsigned a);
    int b;
    if (a >= MB) return 32'h0;
    b = int'(a);
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  task automatic model_beat(input longint unsigned a, input logic [31:0] d, input logic [3:0] s);
    if (a < MB) begin
      for (int k = 0; k < 4; k++) if (s[k]) ref_mem[int'(a) + k] = d[8*k +: 8];
    end
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] burst, input bit early_last, input int bstall,
                          output int lat);
    int n, t0;
    bit err;
    longint unsigned a;
    err = bad_burst(len, burst);
    AWID = id; AWADDR = addr; AWLEN = 8'(len); AWBURST = burst; AWVALID = 1'b1;
    n = 0;
    while (AWREADY !== 1'b1 && n < 100) begin @(negedge ACLK); n++; end
    check("awready", AWREADY, 1);
    @(negedge ACLK);
    AWVALID = 1'b0;
    t0 = cyc;
    for (int i = 0; i <= len; i++) begin
      WVALID = 1'b1; WDATA = wdat[i]; WSTRB = wstb[i]; WLAST = early_last || (i == len);
      n = 0;
      while (WREADY !== 1'b1 && n < 100) begin @(negedge ACLK); n++; end
      check("wready", WREADY, 1);
      @(negedge ACLK);
      a = beat_addr(addr, len, burst, i);
      if (a >= MB) err = 1;
      model_beat(a, wdat[i], wstb[i]);
      if (early_last && i != len) err = 1;
    end
    WVALID = 1'b0; WLAST = 1'b0;
    lat = cyc - t0;
    for (int j = 0; j < bstall; j++) begin
      check("b_hold_valid", BVALID, 1);
      check("b_hold_awready", AWREADY, 0);
      @(negedge ACLK);
    end
    n = 0;
    while (BVALID !== 1'b1 && n < 100) begin @(negedge ACLK); n++; end
    check("bvalid", BVALID, 1);
    check("bid", BID, id);
    check("bresp", BRESP, err ? 2'b10 : 2'b00);
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    check("b_done", BVALID, 0);
    check("aw_rearm", AWREADY, 1);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input logic [1:0] burst, input int stall_at, input int stall_n,
                         output int lat);
    int n, t0;
    bit err;
    longint unsigned a;
    logic [31:0] ed;
    logic [1:0] er;
    ARID = id; ARADDR = addr; ARLEN = 8'(len); ARBURST = burst; ARVALID = 1'b1; RREADY = 1'b0;
    n = 0;
    while (ARREADY !== 1'b1 && n < 100) begin @(negedge ACLK); n++; end
    check("arready", ARREADY, 1);
    @(negedge ACLK);
    ARVALID = 1'b0;
    t0 = cyc;
    check("r_latency", RVALID, 1);
    check("ar_busy", ARREADY, 0);
    for (int i = 0; i <= len; i++) begin
      a = beat_addr(addr, len, burst, i);
      err = bad_burst(len, burst) || (a >= MB);
      ed = ref_word(a);
      er = err ? 2'b10 : 2'b00;
      if (i == stall_at) begin
        for (int j = 0; j < stall_n; j++) begin
          RREADY = 1'b0;
          @(negedge ACLK);
          check("r_stall_valid", RVALID, 1);
          check("r_stall_data", RDATA, ed);
          check("r_stall_last", RLAST, i == len);
          check("r_stall_id", RID, id);
        end
      end
      n = 0;
      while (RVALID !== 1'b1 && n < 100) begin @(negedge ACLK); n++; end
      check("rdata", RDATA, ed);
      check("rresp", RRESP, er);
      check("rlast", RLAST, i == len);
      check("rid", RID, id);
      RREADY = 1'b1;
      @(negedge ACLK);
    end
    RREADY = 1'b0;
    lat = cyc - t0;
    check("r_end", RVALID, 0);
  endtask

  initial begin
    int lw, lr, len, burst;
    logic [31:0] addr;
    ARESETn = 1'b0;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWBURST = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARBURST = '0; ARVALID = 1'b0; RREADY = 1'b0;
    repeat (3) @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    check("rst_awready", AWREADY, 1);
    check("rst_arready", ARREADY, 1);
    check("rst_wready", WREADY, 0);
    check("rst_bvalid", BVALID, 0);
    check("rst_rvalid", RVALID, 0);
    check("rst_rlast", RLAST, 0);
    check("rst_bresp", BRESP, 0);
    check("rst_rresp", RRESP, 0);
    check("rst_rdata", RDATA, 0);
    check("rst_rid", RID, 0);
    check("rst_bid", BID, 0);

    // Fill the whole array so every later read has a defined expectation.
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 256; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
      do_write(4'd0, 32'(b * 1024), 255, 2'b01, 1'b0, 0, lw);
    end

    for (int i = 0; i < 4; i++) begin wdat[i] = 32'hA0 + 32'(i); wstb[i] = 4'hF; end
    do_write(4'd5, 32'h100, 3, 2'b01, 1'b0, 0, lw);
    do_read(4'd9, 32'h100, 3, 2'b01, -1, 0, lr);

    wdat[0] = 32'h11223344; wstb[0] = 4'hF;
    do_write(4'd1, 32'h200, 0, 2'b01, 1'b0, 0, lw);
    wdat[0] = 32'hAABBCCDD; wstb[0] = 4'b0101;
    do_write(4'd2, 32'h200, 0, 2'b01, 1'b0, 0, lw);
    ARID = 4'd3; ARADDR = 32'h200; ARLEN = 8'd0; ARBURST = 2'b01; ARVALID = 1'b1;
    @(negedge ACLK);
    ARVALID = 1'b0;
    check("strb_merge", RDATA, 32'h11BB33DD);
    check("single_rlast", RLAST, 1);
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;

    do_read(4'd4, 32'h18, 3, 2'b10, -1, 0, lr);
    do_read(4'd6, 32'h18, 2, 2'b10, -1, 0, lr);
    do_write(4'd7, 32'h40, 2, 2'b10, 1'b0, 0, lw);

    for (int i = 0; i < 4; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
    do_write(4'd8, 32'hFF8, 3, 2'b01, 1'b0, 0, lw);
    do_read(4'd8, 32'hFF8, 3, 2'b01, -1, 0, lr);

    do_read(4'd10, 32'h100, 3, 2'b01, 2, 5, lr);
    for (int i = 0; i < 2; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
    do_write(4'd11, 32'h140, 1, 2'b01, 1'b0, 3, lw);
    for (int i = 0; i < 3; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
    do_write(4'd12, 32'h180, 2, 2'b01, 1'b1, 0, lw);
    do_read(4'd12, 32'h180, 2, 2'b01, -1, 0, lr);

    for (int i = 0; i < 8; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
    fork
      do_write(4'd13, 32'h400, 7, 2'b01, 1'b0, 0, lw);
      do_read(4'd14, 32'h800, 7, 2'b01, -1, 0, lr);
    join
    check("conc_w_lat", lw <= 9, 1);
    check("conc_r_lat", lr <= 9, 1);
    do_read(4'd13, 32'h400, 7, 2'b01, -1, 0, lr);

    // Reset in the middle of a write burst with a read beat pending.
    for (int i = 0; i < 8; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
    ARID = 4'd2; ARADDR = 32'h900; ARLEN = 8'd3; ARBURST = 2'b01; ARVALID = 1'b1;
    @(negedge ACLK);
    ARVALID = 1'b0;
    AWID = 4'd3; AWADDR = 32'h300; AWLEN = 8'd7; AWBURST = 2'b01; AWVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      WVALID = 1'b1; WDATA = wdat[i]; WSTRB = 4'hF; WLAST = 1'b0;
      @(negedge ACLK);
      model_beat(beat_addr(32'h300, 7, 1, i), wdat[i], 4'hF);
    end
    WDATA = wdat[3];
    ARESETn = 1'b0;
    #1;
    check("mid_rst_rvalid", RVALID, 0);
    check("mid_rst_wready", WREADY, 0);
    check("mid_rst_bvalid", BVALID, 0);
    check("mid_rst_awready", AWREADY, 1);
    check("mid_rst_arready", ARREADY, 1);
    WVALID = 1'b0;
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    do_read(4'd5, 32'h300, 7, 2'b01, -1, 0, lr);

    for (int t = 0; t < 16; t++) begin
      burst = int'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: len = int'($urandom_range(0, 3));
        1: len = 7;
        2: len = 15;
        default: len = int'($urandom_range(0, 20));
      endcase
      addr = $urandom_range(0, MB + 128);
      for (int i = 0; i <= len; i++) begin wdat[i] = $urandom; wstb[i] = 4'($urandom); end
      do_write(4'($urandom), addr, len, 2'(burst), 1'b0, int'($urandom_range(0, 2)), lw);
      do_read(4'($urandom), addr, len, 2'(burst), int'($urandom_range(0, 20)),
              int'($urandom_range(0, 3)), lr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_burst_mem_sub.md
Name: axi_burst_mem_sub

Overview:
Parametrised AXI4 subordinate memory, successor to the single-beat subordinate. Supports INCR/WRAP/FIXED bursts up to 256 beats, byte strobes and transaction IDs. Out-of-range accesses return SLVERR. Write (AW/W/B) and read (AR/R) paths run as independent FSMs over one byte-addressed array, and the block sits behind the interconnect as a leaf subordinate.

Parameters:
DATA_W, 32, data bus width in bits; power of two, 8..256
ADDR_W, 32, address width
ID_W, 4, transaction ID width
MEM_BYTES, 4096, array depth in bytes; power of two and a multiple of DATA_W/8

Ports:
ACLK  in  1  clock
ARESETn  in  1  reset, asynchronous assert, active-low
AWID/AWADDR/AWLEN/AWBURST  in  ID_W/ADDR_W/8/2  write address channel
AWVALID in 1, AWREADY out 1  AW handshake
WDATA/WSTRB/WLAST  in  DATA_W/DATA_W/8/1  write data channel
WVALID in 1, WREADY out 1  W handshake
BID/BRESP  out  ID_W/2  write response (resp_t)
BVALID out 1, BREADY in 1  B handshake
ARID/ARADDR/ARLEN/ARBURST  in  ID_W/ADDR_W/8/2  read address channel
ARVALID in 1, ARREADY out 1  AR handshake
RID/RDATA/RRESP/RLAST  out  ID_W/DATA_W/2/1  read data channel
RVALID out 1, RREADY in 1  R handshake

Behaviour:
- Reset (async on ARESETn low): both FSMs go to IDLE. AWREADY=ARREADY=1; WREADY=BVALID=RVALID=RLAST=0; BRESP=RRESP=OKAY; RDATA, RID and BID=0. Memory contents are not cleared. Reset mid-burst abandons the burst, and no further beats are written.
- Addressing: the low log2(DATA_W/8) address bits are ignored, so every beat is bus-aligned. Beat address = base + i*BYTES.
- FIXED: every beat uses the same address.
- INCR: linear increment.
- WRAP: wraps within a (LEN+1)*BYTES aligned window. LEN must be 1, 3, 7 or 15; any other value responds SLVERR and uses INCR addressing.
- BURST=2'b11 (reserved) responds SLVERR and uses INCR addressing.
- Range: a beat with address >= MEM_BYTES is an error beat. Writes for that beat are suppressed; reads return RDATA=0 and RRESP=SLVERR for that beat only.
- Write FSM:
  - W_IDLE: AWREADY=1. On AW handshake, latch ID/addr/len/burst, clear err, go to W_DATA next cycle with AWREADY=0.
  - W_DATA: WREADY=1. Each W handshake writes byte k of WDATA if WSTRB[k] and the beat is in range, commits at that edge, and advances the address and beat count.
  - Any bad-burst condition, out-of-range beat, or WLAST disagreeing with (count==LEN) sets sticky err.
  - The beat with count==LEN ends the burst regardless of WLAST: WREADY drops and the FSM enters W_RESP.
  - W_RESP: BVALID=1, BID=latched ID, BRESP=SLVERR if err else OKAY. Hold until BREADY, then return to W_IDLE (AWREADY=1 next cycle).
  - W beats arriving while in W_IDLE are not accepted (WREADY=0).
- Read FSM:
  - R_IDLE: ARREADY=1. On AR handshake at edge N, latch the request and register beat 0 into RDATA/RRESP. RVALID=1 from cycle N+1, with ARREADY=0.
  - R_DATA: outputs are held stable while RVALID && !RREADY. On handshake, if the beat was not last, load the next beat at the same edge (no bubble); otherwise RVALID=0 and return to R_IDLE.
  - RLAST=1 exactly on beat LEN. A single-beat burst (LEN=0) asserts RLAST on its only beat.
- Read/write collision: RDATA is loaded from the array state before the same-edge write commits. Old data is returned, and the new data is visible to the next beat load.
- Throughput: one beat per cycle on W and R. One idle cycle between bursts on each path (the IDLE handshake cycle).
- Both channel pairs may be active simultaneously with no mutual stall.

Decomposition:
- axi_helper package gains:
  - burst_t enum (FIXED=2'b00, INCR=2'b01, WRAP=2'b10, RSVD=2'b11)
  - a function axi_next_addr(addr, len, burst, bytes) returning the next beat address
  - existing resp_t (OKAY, SLVERR)
- One sub-module, axi_burst_addr_gen, holds base/len/burst/count, produces the current address, last flag and bad-burst flag. It is instantiated once per path. Memory and both FSMs live in the top.

Test Plan:
- INCR write AWADDR=0x100, AWLEN=3, WSTRB=4'hF, data 0xA0..0xA3, then INCR read of the same range -> BRESP=OKAY with BID echoed; RDATA 0xA0,0xA1,0xA2,0xA3 with RLAST only on beat 3; RVALID appears 1 cycle after the AR handshake.
- Pre-fill 0x200=0x11223344, write 0x200 with WDATA=0xAABBCCDD, WSTRB=4'b0101 -> read returns 0x11BB33DD.
- WRAP read ARADDR=0x18, ARLEN=3 (16-byte window at 0x10) -> beat addresses 0x18,0x1C,0x10,0x14. WRAP with ARLEN=2 -> all RRESP=SLVERR.
- INCR read ARADDR=0xFF8, ARLEN=3, MEM_BYTES=4096 -> beats 0,1 OKAY with data; beats 2,3 RDATA=0, RRESP=SLVERR. The matching write burst gives BRESP=SLVERR and writes only 0xFF8 and 0xFFC.
- RREADY held low for 5 cycles mid-burst -> RDATA/RID/RLAST stable, no beat lost. BREADY low for 3 cycles -> BVALID held, AWREADY=0 throughout.
- Concurrent 8-beat write and 8-beat read to disjoint regions -> both complete within 9 cycles of their address handshakes. Assert ARESETn low mid-write burst -> all VALIDs drop immediately and unwritten beats are not committed.
